// File: rtl/iob_plic_gateway.sv
// Interrupt gateway for iob_plic: synchronises raw IRQ lines, applies level/edge
// mode and holds one request per source until the target completes it.
module iob_plic_gateway #(
  parameter  int N_SOURCES   = 8,
  parameter  int SYNC_STAGES = 2,
  parameter  int CNT_W       = 3,
  localparam int ID_W        = $clog2(N_SOURCES + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_SOURCES-1:0] irq_i,
  input  logic [N_SOURCES-1:0] edge_en_i,
  input  logic                 claim_i,
  input  logic [ID_W-1:0]      claim_id_i,
  input  logic                 complete_i,
  input  logic [ID_W-1:0]      complete_id_i,
  output logic [N_SOURCES-1:0] srip_o
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PENDING  = 2'd1;
  localparam logic [1:0] ST_INFLIGHT = 2'd2;

  logic [SYNC_STAGES-1:0][N_SOURCES-1:0] sync_q;
  logic [N_SOURCES-1:0]                  s;
  logic [N_SOURCES-1:0]                  p_q;
  logic [N_SOURCES-1:0]                  rise;
  logic [N_SOURCES-1:0]                  edge_q;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~p_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      p_q    <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= irq_i;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      p_q    <= s;
      edge_q <= edge_en_i;
    end
  end

  for (genvar i = 0; i < N_SOURCES; i++) begin : g_src
    logic [1:0]       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             claim_hit, complete_hit, claim_ok, cnt_nz, req;

    always_comb begin
      claim_hit    = claim_i    && (claim_id_i    == ID_W'(i + 1));
      complete_hit = complete_i && (complete_id_i == ID_W'(i + 1));
      claim_ok     = claim_hit && (st_q == ST_PENDING);
      cnt_nz       = (cnt_q != '0);
      req          = edge_en_i[i] ? (cnt_nz | rise[i]) : s[i];

      // A claim coinciding with a new edge consumes that edge, leaving cnt unchanged.
      cnt_d = cnt_q;
      if (edge_en_i[i] != edge_q[i]) begin
        cnt_d = '0;
      end else if (edge_en_i[i]) begin
        if (claim_ok) begin
          if (!rise[i] && cnt_nz) cnt_d = cnt_q - 1'b1;
        end else if (rise[i] && (cnt_q != '1)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      st_d = st_q;
      case (st_q)
        ST_IDLE:     if (req)          st_d = ST_PENDING;
        ST_PENDING:  if (claim_hit)    st_d = ST_INFLIGHT;
        ST_INFLIGHT: if (complete_hit) st_d = req ? ST_PENDING : ST_IDLE;
        default:                       st_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        st_q  <= ST_IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    assign srip_o[i] = (st_q == ST_PENDING);
  end

endmodule

// File: tb/tb_iob_plic_gateway.sv
// Directed self-checking bench for iob_plic_gateway (8 sources, 2-stage sync, 3-bit counters).
module tb_iob_plic_gateway;

  localparam int N    = 8;
  localparam int ID_W = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [N-1:0]  irq_i;
  logic [N-1:0]  edge_en_i;
  logic          claim_i;
  logic [ID_W-1:0] claim_id_i;
  logic          complete_i;
  logic [ID_W-1:0] complete_id_i;
  logic [N-1:0]  srip_o;

  int tests = 0;
  int fails = 0;

  iob_plic_gateway #(.N_SOURCES(8), .SYNC_STAGES(2), .CNT_W(3)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .irq_i         (irq_i),
    .edge_en_i     (edge_en_i),
    .claim_i       (claim_i),
    .claim_id_i    (claim_id_i),
    .complete_i    (complete_i),
    .complete_id_i (complete_id_i),
    .srip_o        (srip_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_claim(input int id);
    claim_i = 1'b1; claim_id_i = ID_W'(id);
    tick();
    claim_i = 1'b0; claim_id_i = '0;
  endtask

  task automatic do_complete(input int id);
    complete_i = 1'b1; complete_id_i = ID_W'(id);
    tick();
    complete_i = 1'b0; complete_id_i = '0;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    irq_i = m;  tick();
    irq_i = '0; tick();
  endtask

  int delivered;

  initial begin
    rst_i = 1'b1; irq_i = 8'hFF; edge_en_i = '0;
    claim_i = 1'b0; claim_id_i = '0; complete_i = 1'b0; complete_id_i = '0;

    // reset held with all lines high
    tick(); check("rst_c1", srip_o, 8'h00);
    tick(); check("rst_c2", srip_o, 8'h00);
    tick(); check("rst_c3", srip_o, 8'h00);
    rst_i = 1'b0;
    tick(); check("rel_c1", srip_o, 8'h00);
    tick(); check("rel_c2", srip_o, 8'h00);
    tick(); check("rel_c3", srip_o, 8'hFF);

    rst_i = 1'b1; irq_i = '0; tick(); rst_i = 1'b0; tick();
    check("clean", srip_o, 8'h00);

    // level source 3
    irq_i = 8'h04; ticks(3);
    check("lvl_pend", srip_o, 8'h04);
    do_claim(3);    check("lvl_claim", srip_o, 8'h00);
    ticks(2);       check("lvl_inflight", srip_o, 8'h00);
    do_complete(3); check("lvl_cmp_hi", srip_o, 8'h04);
    do_claim(3);    check("lvl_claim2", srip_o, 8'h00);
    irq_i = '0; ticks(3);
    do_complete(3); check("lvl_cmp_lo", srip_o, 8'h00);
    tick();         check("lvl_idle", srip_o, 8'h00);

    // claim/complete filtering
    irq_i = 8'h04; ticks(3);
    check("flt_pend", srip_o, 8'h04);
    do_claim(0);    check("flt_id0", srip_o, 8'h04);
    do_claim(9);    check("flt_id9", srip_o, 8'h04);
    do_complete(5); check("flt_cmp_idle", srip_o, 8'h04);
    do_complete(3); check("flt_cmp_pend", srip_o, 8'h04);
    do_claim(3);    check("flt_claim_ok", srip_o, 8'h00);
    irq_i = '0; ticks(3);
    do_complete(3); check("flt_done", srip_o, 8'h00);

    // same-cycle claim and complete on different IDs
    irq_i = 8'h0C; ticks(3);
    check("dual_pend", srip_o, 8'h0C);
    do_claim(3);   check("dual_claim3", srip_o, 8'h08);
    claim_i = 1'b1; claim_id_i = 4'd4; complete_i = 1'b1; complete_id_i = 4'd3;
    tick();
    claim_i = 1'b0; complete_i = 1'b0;
    check("dual_both", srip_o, 8'h04);
    irq_i = '0; rst_i = 1'b1; tick(); rst_i = 1'b0; tick();

    // edge source 1: 4 edges queued while in flight
    edge_en_i = 8'h01; tick();
    pulse(8'h01); tick();
    check("edg_pend", srip_o, 8'h01);
    do_claim(1);  check("edg_claim", srip_o, 8'h00);
    for (int i = 0; i < 4; i++) pulse(8'h01);
    ticks(2);     check("edg_inflight", srip_o, 8'h00);
    do_complete(1); check("edg_cmp1", srip_o, 8'h01);
    for (int i = 0; i < 3; i++) begin
      do_claim(1);    check("edg_loop_claim", srip_o, 8'h00);
      do_complete(1); check("edg_loop_cmp", srip_o, 8'h01);
    end
    do_claim(1);    check("edg_last_claim", srip_o, 8'h00);
    do_complete(1); check("edg_cmp5", srip_o, 8'h00);
    tick();         check("edg_idle", srip_o, 8'h00);

    // edge saturation: 10 edges, counter caps at 7
    for (int i = 0; i < 10; i++) pulse(8'h01);
    ticks(2);
    check("sat_pend", srip_o, 8'h01);
    delivered = 0;
    for (int k = 0; k < 10; k++) begin
      if (srip_o[0]) begin
        do_claim(1);
        do_complete(1);
        delivered++;
      end
    end
    check("sat_count", delivered, 7);
    check("sat_idle", srip_o, 8'h00);

    // reset while source 2 is in flight with cnt=3
    edge_en_i = 8'h02; ticks(2);
    pulse(8'h02); tick();
    check("mr_pend", srip_o, 8'h02);
    do_claim(2);  check("mr_claim", srip_o, 8'h00);
    for (int i = 0; i < 3; i++) pulse(8'h02);
    ticks(2);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    check("mr_rst", srip_o, 8'h00);
    ticks(4);       check("mr_cnt0", srip_o, 8'h00);
    do_complete(2); check("mr_cmp_ign", srip_o, 8'h00);
    tick();         check("mr_final", srip_o, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
